bullet_table_writer: RTL
========================

Name: bullet_table_writer

Overview:
Owns the 64-slot bullet table that the VGA display path reads as a flat 2048-bit bus. It spawns bullets on fire requests from the game CPU/joystick logic and advances every active bullet once per frame. It also retires bullets that leave the 640x480 screen. It sits between the game logic and the VGA controller's bullet input, and is the single writer of that bus.

Parameters:
MAX_BULLETS, 64, number of bullet slots (32-bit word each)
BULLET_SIZE, 12, bullet square edge in pixels, used for bounds checks
VIDEO_WIDTH, 640, screen width in pixels
VIDEO_HEIGHT, 480, screen height in pixels
SPEED, 4, pixels moved per frame update

Ports:
clk  in  1  25 MHz pixel clock shared with VGA timing
CPU_RESETN  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame (VGA screenEnd)
fire_valid  in  1  spawn request
fire_ready  out  1  spawn accepted when fire_valid&&fire_ready at rising edge
fire_x  in  10  spawn x (top-left)
fire_y  in  9  spawn y (top-left)
fire_dir  in  2  00 up, 01 down, 10 left, 11 right
fire_owner  in  1  0 = P1, 1 = P2
allBulletContents  out  32*MAX_BULLETS  packed table; slot j at [j*32 +: 32]
active_count  out  7  number of active slots
spawn_drop  out  1  one-cycle pulse: accepted fire found no free slot
busy  out  1  high while in UPDATE

Behaviour:
- Slot word: [31:22] x, [21:13] y, [12:11] dir, [10] owner, [2] active; all other bits 0. All outputs registered.
- Reset (CPU_RESETN low, async): all slots 0, active_count 0, spawn_drop 0, busy 0, fire_ready 0, tick_pending 0, state IDLE. fire_ready rises on the first clock after release.
- States: IDLE, UPDATE.
- fire_ready = (state==IDLE) && !tick_pending.
- IDLE, accepted fire: write the lowest-index slot with active==0 on the same edge. Fields: {fire_x, fire_y, fire_dir, fire_owner, active=1}. active_count+1.
- IDLE, accepted fire, no free slot: table unchanged; spawn_drop pulses for 1 cycle on the next cycle.
- frame_tick in any state sets tick_pending. Multiple ticks before service coalesce into one update.
- IDLE with tick_pending: go to UPDATE next edge, slot index 0, busy=1, tick_pending cleared.
- frame_tick in the same IDLE cycle as an accepted fire: the spawn happens that edge; UPDATE starts the following cycle. The new bullet moves in that update.
- UPDATE: process one slot per clock, index 0..MAX_BULLETS-1, so the pass lasts MAX_BULLETS cycles. Then return to IDLE and busy=0.
- Inactive slot in UPDATE: unchanged.
- Active slot in UPDATE, moved by SPEED in dir. Checks use 11-bit unsigned arithmetic with no wrap:
  - up: if y < SPEED, deactivate; else y -= SPEED.
  - down: if y+SPEED+BULLET_SIZE > VIDEO_HEIGHT, deactivate; else y += SPEED.
  - left: if x < SPEED, deactivate; else x -= SPEED.
  - right: if x+SPEED+BULLET_SIZE > VIDEO_WIDTH, deactivate; else x += SPEED.
- Deactivate clears bit 2 only (coordinates retained) and decrements active_count.
- Spawn positions are not checked; an out-of-bounds spawn is retired by the next update.
- Each slot word on the bus changes on the edge its slot is processed. A 64-cycle pass fits within vertical blanking, so no mid-frame tearing.
- active_count always equals the popcount of the active bits; it saturates at MAX_BULLETS.

Test Plan:
- Reset then 3 fires (x=100,y=200,dir=11), (x=50,y=50,dir=00), (x=0,y=0,dir=10): slots 0,1,2 active, words correct, active_count=3, fire_ready low only during reset and the first post-reset cycle.
- One frame_tick after the above: busy high exactly 64 cycles. Slot0 x=104. Slot1 y=46. Slot2 deactivated with x=0 retained. active_count=2; fire_ready low throughout UPDATE.
- Right-moving bullet at x=624: first tick gives x=624+4, and 628+12 ≤ 640 so it stays active. Next tick needs 644 > 640, so it deactivates. Repeat the check on the y-axis at y=464.
- 64 fires then a 65th: all slots active, active_count=64, and the 65th raises a spawn_drop pulse for one cycle with the table unchanged. Free slot 5 via update, fire again: slot 5 is refilled (lowest free).
- fire_valid held during UPDATE, plus a 2nd frame_tick mid-UPDATE: no spawn until IDLE. Exactly one extra UPDATE pass runs after the current one. The held fire is accepted in the IDLE cycle between passes, only if tick_pending is clear; otherwise after the second pass.
- Assert CPU_RESETN mid-UPDATE (slot 30): all outputs immediately 0 and state IDLE, with no partial update retained.

Source files
------------

// File: rtl/bullet_table_writer.sv
// Bullet table owner: spawns bullets on fire requests, advances and
// retires them once per frame, and drives the flat table read by VGA.
module bullet_table_writer #(
    parameter int MAX_BULLETS  = 64,
    parameter int BULLET_SIZE  = 12,
    parameter int VIDEO_WIDTH  = 640,
    parameter int VIDEO_HEIGHT = 480,
    parameter int SPEED        = 4
) (
    input  logic                      clk,
    input  logic                      CPU_RESETN,
    input  logic                      frame_tick,
    input  logic                      fire_valid,
    output logic                      fire_ready,
    input  logic [9:0]                fire_x,
    input  logic [8:0]                fire_y,
    input  logic [1:0]                fire_dir,
    input  logic                      fire_owner,
    output logic [32*MAX_BULLETS-1:0] allBulletContents,
    output logic [6:0]                active_count,
    output logic                      spawn_drop,
    output logic                      busy
);

    localparam int IDX_W = $clog2(MAX_BULLETS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_BULLETS - 1);
    localparam logic [10:0] STEP   = 11'(SPEED);
    localparam logic [10:0] SIZE   = 11'(BULLET_SIZE);
    localparam logic [10:0] WIDTH  = 11'(VIDEO_WIDTH);
    localparam logic [10:0] HEIGHT = 11'(VIDEO_HEIGHT);

    typedef enum logic {IDLE, UPDATE} stateType;

    stateType                     state;
    stateType                     stateNext;
    logic                         tickPending;
    logic                         tickPendingNext;
    logic [IDX_W-1:0]             slotIdx;
    logic [MAX_BULLETS-1:0][31:0] slots;
    logic                         fireAccept;
    logic                         freeFound;
    logic [IDX_W-1:0]             freeIdx;
    logic [31:0]                  curWord;
    logic [31:0]                  movedWord;
    logic                         retire;
    logic [10:0]                  curX;
    logic [10:0]                  curY;

    assign allBulletContents = slots;
    assign busy              = (state == UPDATE);
    assign fireAccept        = fire_valid && fire_ready;

    // Next state: a pending tick starts a pass; ticks coalesce into one flag.
    always_comb begin
        stateNext       = state;
        tickPendingNext = tickPending || frame_tick;
        unique case (state)
            IDLE: begin
                if (tickPending) begin
                    stateNext       = UPDATE;
                    tickPendingNext = frame_tick;
                end
            end
            UPDATE: begin
                if (slotIdx == LAST_IDX) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Lowest-index inactive slot for the next spawn.
    always_comb begin
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int j = MAX_BULLETS - 1; j >= 0; j--) begin
            if (!slots[j][2]) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(j);
            end
        end
    end

    // Move the slot under the update pointer, retiring it if it leaves.
    always_comb begin
        curWord   = slots[slotIdx];
        curX      = {1'b0, curWord[31:22]};
        curY      = {2'b00, curWord[21:13]};
        movedWord = curWord;
        retire    = 1'b0;
        if (curWord[2]) begin
            unique case (curWord[12:11])
                2'b00: begin
                    if (curY < STEP) retire = 1'b1;
                    else movedWord[21:13] = 9'(curY - STEP);
                end
                2'b01: begin
                    if (curY + STEP + SIZE > HEIGHT) retire = 1'b1;
                    else movedWord[21:13] = 9'(curY + STEP);
                end
                2'b10: begin
                    if (curX < STEP) retire = 1'b1;
                    else movedWord[31:22] = 10'(curX - STEP);
                end
                2'b11: begin
                    if (curX + STEP + SIZE > WIDTH) retire = 1'b1;
                    else movedWord[31:22] = 10'(curX + STEP);
                end
            endcase
            if (retire) movedWord[2] = 1'b0;
        end
    end

    // Control registers: state, pending tick, pass pointer, spawn readiness.
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state       <= IDLE;
            tickPending <= 1'b0;
            slotIdx     <= '0;
            fire_ready  <= 1'b0;
        end else begin
            state       <= stateNext;
            tickPending <= tickPendingNext;
            slotIdx     <= (state == UPDATE) ? slotIdx + IDX_W'(1) : '0;
            fire_ready  <= (stateNext == IDLE) && !tickPendingNext;
        end
    end

    // Table writes: spawn into the free slot, or rewrite the visited slot.
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            slots <= '0;
        end else if (fireAccept && freeFound) begin
            slots[freeIdx] <= {fire_x, fire_y, fire_dir, fire_owner,
                               7'b0, 1'b1, 2'b00};
        end else if (state == UPDATE) begin
            slots[slotIdx] <= movedWord;
        end
    end

    // Population count tracking and the table-full drop pulse.
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            active_count <= '0;
            spawn_drop   <= 1'b0;
        end else begin
            spawn_drop <= fireAccept && !freeFound;
            if (fireAccept && freeFound) begin
                active_count <= active_count + 7'd1;
            end else if (state == UPDATE && retire) begin
                active_count <= active_count - 7'd1;
            end
        end
    end

endmodule
